// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns debounced buttons and the 100 Hz tick
// into registered enable/clear/load commands for the min:sec:cs counter chain.
module stopwatch_ctrl #(
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop_in,
  input  logic       lap_in,
  input  logic       clear_in,
  input  logic       mode_up,
  input  logic       at_limit,
  output logic       cnt_en,
  output logic       cnt_clear,
  output logic       cnt_load,
  output logic       up_down,
  output logic       disp_hold,
  output logic       done,
  output logic       blink,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t     state_q, state_d;
  logic       ss_prev, lap_prev, clr_prev;
  logic       ss_edge, lap_edge, clr_edge, limit_evt;
  logic       en_d, clr_d, load_d, up_d, hold_d, blink_d;
  logic [7:0] bcnt_q, bcnt_d;

  assign ss_edge   = start_stop_in & ~ss_prev;
  assign lap_edge  = lap_in & ~lap_prev;
  assign clr_edge  = clear_in & ~clr_prev;
  assign limit_evt = tick & at_limit;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    load_d  = 1'b0;
    up_d    = up_down;
    hold_d  = disp_hold;
    blink_d = blink;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (ss_edge) begin
          state_d = RUN;
          up_d    = mode_up;
          clr_d   = mode_up;
          load_d  = ~mode_up;
        end
      end
      RUN, LAP: begin
        // The limit tick never reaches the chain, so it cannot wrap.
        if (limit_evt) begin
          state_d = DONE;
          hold_d  = 1'b0;
        end else if (ss_edge) begin
          state_d = PAUSE;
          hold_d  = 1'b0;
        end else begin
          en_d = tick;
          if (lap_edge) begin
            state_d = (state_q == RUN) ? LAP : RUN;
            hold_d  = (state_q == RUN);
          end
        end
      end
      PAUSE: begin
        if (clr_edge) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (ss_edge) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (clr_edge) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          blink_d = 1'b0;
          bcnt_d  = '0;
        end else if (tick) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ss_prev   <= 1'b1;
      lap_prev  <= 1'b1;
      clr_prev  <= 1'b1;
      cnt_en    <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_load  <= 1'b0;
      up_down   <= 1'b1;
      disp_hold <= 1'b0;
      blink     <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ss_prev   <= start_stop_in;
      lap_prev  <= lap_in;
      clr_prev  <= clear_in;
      cnt_en    <= en_d;
      cnt_clear <= clr_d;
      cnt_load  <= load_d;
      up_down   <= up_d;
      disp_hold <= hold_d;
      blink     <= blink_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule
